// File: rtl/ship_steer_ctrl_pkg.sv
// Shared constants for the ship steering controller: compass codes, heading step ROMs
// and the default tick divider.
package ship_steer_ctrl_pkg;

  localparam logic [23:0] DEFAULT_TICK_DIV = 24'd833333;

  localparam logic [3:0] DIR_N  = 4'b0001;
  localparam logic [3:0] DIR_NE = 4'b0101;
  localparam logic [3:0] DIR_E  = 4'b0100;
  localparam logic [3:0] DIR_SE = 4'b0110;
  localparam logic [3:0] DIR_S  = 4'b0010;
  localparam logic [3:0] DIR_SW = 4'b1010;
  localparam logic [3:0] DIR_W  = 4'b1000;
  localparam logic [3:0] DIR_NW = 4'b1001;

  typedef logic signed [2:0] step_t;

  localparam logic [3:0] DIR_CODES [8] = '{DIR_N, DIR_NE, DIR_E, DIR_SE,
                                           DIR_S, DIR_SW, DIR_W, DIR_NW};

  // Screen y grows downward, so north is a negative dy.
  localparam step_t DX8 [8] = '{3'sd0, 3'sd1, 3'sd1, 3'sd1, 3'sd0, -3'sd1, -3'sd1, -3'sd1};
  localparam step_t DY8 [8] = '{-3'sd1, -3'sd1, 3'sd0, 3'sd1, 3'sd1, 3'sd1, 3'sd0, -3'sd1};

  localparam step_t DX16 [16] = '{3'sd0, 3'sd1, 3'sd2, 3'sd2, 3'sd2, 3'sd2, 3'sd2, 3'sd1,
                                  3'sd0, -3'sd1, -3'sd2, -3'sd2, -3'sd2, -3'sd2, -3'sd2, -3'sd1};
  localparam step_t DY16 [16] = '{-3'sd2, -3'sd2, -3'sd2, -3'sd1, 3'sd0, 3'sd1, 3'sd2, 3'sd2,
                                  3'sd2, 3'sd2, 3'sd2, 3'sd1, 3'sd0, -3'sd1, -3'sd2, -3'sd2};

endpackage

// File: rtl/ship_heading_lut.sv
// Combinational heading -> {dir_code, step_dx, step_dy} lookup for 8 or 16 headings.
module ship_heading_lut
  import ship_steer_ctrl_pkg::*;
#(
  parameter int  N_DIR = 8,
  localparam int HW    = $clog2(N_DIR)
) (
  input  logic [HW-1:0]     heading,
  output logic [3:0]        dir_code,
  output logic signed [2:0] step_dx,
  output logic signed [2:0] step_dy
);

  if (N_DIR == 16) begin : g_16
    // Odd headings borrow the octant clockwise of them.
    assign dir_code = DIR_CODES[3'((heading + 4'd1) >> 1)];
    assign step_dx  = DX16[heading];
    assign step_dy  = DY16[heading];
  end else begin : g_8
    assign dir_code = DIR_CODES[heading];
    assign step_dx  = DX8[heading];
    assign step_dy  = DY8[heading];
  end

endmodule

// File: rtl/ship_steer_ctrl.sv
// Ship steering and fire controller: held keys -> heading, step vector, move and rate-limited fire pulses.
// `define SHIP_FIRE_AUTOREPEAT_EN to re-arm the fire request every tick while shoot is held.
module ship_steer_ctrl
  import ship_steer_ctrl_pkg::*;
#(
  parameter int          N_DIR         = 8,
  parameter logic [23:0] TICK_DIV      = DEFAULT_TICK_DIV,
  parameter int          ROT_TICKS     = 2,
  parameter int          FIRE_COOLDOWN = 8,
  parameter int          MAX_SHOTS     = 4,
  localparam int         HW            = $clog2(N_DIR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              rotate_left,
  input  logic              rotate_right,
  input  logic              forward,
  input  logic              shoot,
  input  logic              shot_done,
  output logic [HW-1:0]     heading,
  output logic [3:0]        dir_code,
  output logic signed [2:0] step_dx,
  output logic signed [2:0] step_dy,
  output logic              move_pulse,
  output logic              fire_pulse,
  output logic [3:0]        shots_active
);

  localparam int          RW          = (ROT_TICKS > 1) ? $clog2(ROT_TICKS) : 1;
  localparam int          CW          = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;
  localparam logic [RW-1:0] ROT_RELOAD = RW'(ROT_TICKS - 1);
  localparam logic [CW-1:0] CD_RELOAD  = CW'(FIRE_COOLDOWN);
  localparam logic [3:0]  SHOT_LIMIT  = 4'(MAX_SHOTS);
  localparam logic [23:0] TICK_RELOAD = TICK_DIV - 24'd1;
  localparam step_t       DY_RESET    = (N_DIR == 16) ? -3'sd2 : -3'sd1;

  logic [23:0]   tick_cnt_q, tick_cnt_d;
  logic [RW-1:0] rot_cnt_q, rot_cnt_d;
  logic [HW-1:0] heading_q, heading_d;
  logic [3:0]    dir_code_q, dir_code_d;
  step_t         step_dx_q, step_dx_d, step_dy_q, step_dy_d;
  logic [CW-1:0] cd_q, cd_d;
  logic          req_q, req_d;
  logic          shoot_q, shoot_d;
  logic [3:0]    shots_q, shots_d;

  logic          tick, fire, rot_one;
  logic [CW-1:0] cd_next;

  ship_heading_lut #(.N_DIR(N_DIR)) u_lut (
    .heading  (heading_d),
    .dir_code (dir_code_d),
    .step_dx  (step_dx_d),
    .step_dy  (step_dy_d)
  );

  always_comb begin
    tick       = enable && !reset && (tick_cnt_q == '0);
    rot_one    = rotate_left ^ rotate_right;
    cd_next    = (cd_q != '0) ? cd_q - CW'(1) : '0;
    // Cooldown counts down on this tick first, so a fire lands exactly FIRE_COOLDOWN ticks after the last.
    fire       = tick && req_q && (cd_next == '0) && (shots_q < SHOT_LIMIT);

    tick_cnt_d = tick_cnt_q;
    rot_cnt_d  = rot_cnt_q;
    heading_d  = heading_q;
    cd_d       = cd_q;
    req_d      = req_q;
    shoot_d    = shoot_q;
    shots_d    = shots_q;

    if (enable) begin
      tick_cnt_d = tick ? TICK_RELOAD : tick_cnt_q - 24'd1;
      shoot_d    = shoot;

      if (tick) begin
        if (rot_one) begin
          if (rot_cnt_q == '0) begin
            heading_d = rotate_right ? heading_q + HW'(1) : heading_q - HW'(1);
            rot_cnt_d = ROT_RELOAD;
          end else begin
            rot_cnt_d = rot_cnt_q - RW'(1);
          end
        end else begin
          rot_cnt_d = '0;
        end
        cd_d = fire ? CD_RELOAD : cd_next;
      end

      if (fire) begin
        req_d = 1'b0;
      end else if (shoot && !shoot_q) begin
        req_d = 1'b1;
`ifdef SHIP_FIRE_AUTOREPEAT_EN
      end else if (tick && shoot) begin
        req_d = 1'b1;
`endif
      end

      if (fire && !shot_done) begin
        shots_d = shots_q + 4'd1;
      end else if (!fire && shot_done && shots_q != '0) begin
        shots_d = shots_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= TICK_RELOAD;
      rot_cnt_q  <= '0;
      heading_q  <= '0;
      dir_code_q <= DIR_N;
      step_dx_q  <= 3'sd0;
      step_dy_q  <= DY_RESET;
      cd_q       <= '0;
      req_q      <= 1'b0;
      shoot_q    <= 1'b0;
      shots_q    <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      rot_cnt_q  <= rot_cnt_d;
      heading_q  <= heading_d;
      dir_code_q <= dir_code_d;
      step_dx_q  <= step_dx_d;
      step_dy_q  <= step_dy_d;
      cd_q       <= cd_d;
      req_q      <= req_d;
      shoot_q    <= shoot_d;
      shots_q    <= shots_d;
    end
  end

  assign heading      = heading_q;
  assign dir_code     = dir_code_q;
  assign step_dx      = step_dx_q;
  assign step_dy      = step_dy_q;
  assign move_pulse   = tick && forward;
  assign fire_pulse   = fire;
  assign shots_active = shots_q;

endmodule

// File: tb/tb_ship_steer_ctrl.sv
// Bench for ship_steer_ctrl: an 8-heading and a 16-heading instance share stimulus and are
// compared every cycle against a behavioural game-tick model, plus directed scenario checks.
module tb_ship_steer_ctrl;

  localparam int TDIV = 4;
  localparam int ROT  = 2;
  localparam int CDN  = 3;

  logic clk = 1'b0;
  logic reset, enable, rl, rr, fwd, shoot, done;

  logic [2:0]        h8;
  logic [3:0]        dc8, sa8;
  logic signed [2:0] dx8, dy8;
  logic              mv8, fr8;
  logic [3:0]        h16, dc16, sa16;
  logic signed [2:0] dx16, dy16;
  logic              mv16, fr16;

  always #5 clk = ~clk;

  ship_steer_ctrl #(.N_DIR(8), .TICK_DIV(24'd4), .ROT_TICKS(ROT), .FIRE_COOLDOWN(CDN), .MAX_SHOTS(4)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .rotate_left(rl), .rotate_right(rr),
    .forward(fwd), .shoot(shoot), .shot_done(done), .heading(h8), .dir_code(dc8),
    .step_dx(dx8), .step_dy(dy8), .move_pulse(mv8), .fire_pulse(fr8), .shots_active(sa8));

  ship_steer_ctrl #(.N_DIR(16), .TICK_DIV(24'd4), .ROT_TICKS(ROT), .FIRE_COOLDOWN(CDN), .MAX_SHOTS(1)) dut16 (
    .clk(clk), .reset(reset), .enable(enable), .rotate_left(rl), .rotate_right(rr),
    .forward(fwd), .shoot(shoot), .shot_done(done), .heading(h16), .dir_code(dc16),
    .step_dx(dx16), .step_dy(dy16), .move_pulse(mv16), .fire_pulse(fr16), .shots_active(sa16));

  // Reference data straight from the compass/step tables.
  int nd[2]     = '{8, 16};
  int mx[2]     = '{4, 1};
  int dcode[8]  = '{1, 5, 4, 6, 2, 10, 8, 9};
  int dx8t[8]   = '{0, 1, 1, 1, 0, -1, -1, -1};
  int dy8t[8]   = '{-1, -1, 0, 1, 1, 1, 0, -1};
  int dx16t[16] = '{0, 1, 2, 2, 2, 2, 2, 1, 0, -1, -2, -2, -2, -2, -2, -1};
  int dy16t[16] = '{-2, -2, -2, -1, 0, 1, 2, 2, 2, 2, 2, 1, 0, -1, -2, -2};

  // Model state: cycles to next tick, rotation holdoff, heading, pending request, cooldown, shots, last shoot level.
  int m_t[2], m_rot[2], m_h[2], m_req[2], m_cd[2], m_sh[2], m_prev[2];

  int  n_asrt = 0;
  int  n_fail = 0;
  bit  checking = 1'b0;
  int  ticks = 0;
  int  pulses_obs = 0;
  int  cap_mv[2], cap_fr[2], cap_dx[2], cap_dy[2], last_fire_tick[2];

  task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] expv);
    n_asrt++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int exp_dir(int k, int h);
    return (nd[k] == 8) ? dcode[h] : dcode[((h + 1) / 2) % 8];
  endfunction

  function automatic int exp_fire(int k, bit tk);
    // Cooldown of 1 expires on this very tick.
    return (tk && m_req[k] != 0 && m_cd[k] <= 1 && m_sh[k] < mx[k]) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_t[k] = TDIV - 1; m_rot[k] = 0; m_h[k] = 0; m_req[k] = 0;
      m_cd[k] = 0; m_sh[k] = 0; m_prev[k] = 0;
    end
  endtask

  task automatic model_step(int k, bit tk);
    int f;
    f = exp_fire(k, tk);
    if (!enable) return;
    m_t[k] = tk ? TDIV - 1 : m_t[k] - 1;
    if (tk) begin
      if (rl != rr) begin
        if (m_rot[k] == 0) begin
          m_h[k]   = (m_h[k] + (rr ? 1 : -1) + nd[k]) % nd[k];
          m_rot[k] = ROT - 1;
        end else m_rot[k]--;
      end else m_rot[k] = 0;
      if (f != 0) m_cd[k] = CDN; else if (m_cd[k] > 0) m_cd[k]--;
    end
    if (f != 0) m_req[k] = 0;
    else if (shoot && m_prev[k] == 0) m_req[k] = 1;
`ifdef SHIP_FIRE_AUTOREPEAT_EN
    else if (tk && shoot) m_req[k] = 1;
`endif
    m_prev[k] = shoot ? 1 : 0;
    if (f != 0 && !done) m_sh[k]++;
    else if (f == 0 && done && m_sh[k] > 0) m_sh[k]--;
  endtask

  task automatic chk_dut(int k, bit tk, logic signed [31:0] oh, logic signed [31:0] odc,
                         logic signed [31:0] odx, logic signed [31:0] ody,
                         logic signed [31:0] omv, logic signed [31:0] ofr, logic signed [31:0] osa);
    string s;
    s = (k == 0) ? "n8" : "n16";
    if (checking) begin
      chk({s, "_heading"}, oh, m_h[k]);
      chk({s, "_dir_code"}, odc, exp_dir(k, m_h[k]));
      chk({s, "_step_dx"}, odx, (k == 0) ? dx8t[m_h[k]] : dx16t[m_h[k]]);
      chk({s, "_step_dy"}, ody, (k == 0) ? dy8t[m_h[k]] : dy16t[m_h[k]]);
      chk({s, "_move_pulse"}, omv, (tk && fwd) ? 1 : 0);
      chk({s, "_fire_pulse"}, ofr, exp_fire(k, tk));
      chk({s, "_shots_active"}, osa, m_sh[k]);
    end
    if (omv != 0 || ofr != 0) pulses_obs++;
    if (tk) begin
      cap_mv[k] = omv; cap_fr[k] = ofr; cap_dx[k] = odx; cap_dy[k] = ody;
      if (ofr != 0) last_fire_tick[k] = ticks;
    end
  endtask

  task automatic cycle();
    bit tk;
    @(negedge clk);
    tk = !reset && enable && m_t[0] == 0;
    if (tk) ticks++;
    chk_dut(0, tk, h8, dc8, dx8, dy8, mv8, fr8, sa8);
    chk_dut(1, tk, h16, dc16, dx16, dy16, mv16, fr16, sa16);
    if (reset) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k, tk);
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(int n);
    int target, guard;
    target = ticks + n;
    guard  = 0;
    while (ticks < target && guard < 40 * n) begin
      cycle();
      guard++;
    end
    if (ticks < target) chk("tick_timeout", ticks, target);
  endtask

  task automatic to_tick();
    int guard;
    guard = 0;
    while (m_t[0] != 0 && guard < 40) begin
      cycle();
      guard++;
    end
    if (m_t[0] != 0) chk("to_tick_timeout", m_t[0], 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic press_shoot();
    shoot = 1'b1;
    cycle();
    shoot = 1'b0;
  endtask

  initial begin
    int f1, hb8, pb;
    reset = 1'b1; enable = 1'b1; rl = 1'b0; rr = 1'b0; fwd = 1'b0; shoot = 1'b0; done = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    checking = 1'b1;
    do_reset();

    chk("rst_heading8", h8, 0);
    chk("rst_dir8", dc8, 1);
    chk("rst_dx8", dx8, 0);
    chk("rst_dy8", dy8, -1);
    chk("rst_dy16", dy16, -2);
    chk("rst_shots8", sa8, 0);

    // Held right: rotates on ticks 1, 3, 5.
    rr = 1'b1;
    tick_n(1); chk("rr_t1_heading", h8, 1); chk("rr_t1_dir", dc8, 5);
    tick_n(2); chk("rr_t3_heading", h8, 2); chk("rr_t3_dir", dc8, 4);
    tick_n(2); chk("rr_t5_heading", h8, 3); chk("rr_t5_dir", dc8, 6);
    chk("rr_t5_dx", dx8, 1); chk("rr_t5_dy", dy8, 1);
    chk("rr16_heading", h16, 3); chk("rr16_dir", dc16, 4);
    rr = 1'b0;

    // Left wrap from heading 0.
    do_reset();
    rl = 1'b1;
    tick_n(1);
    chk("rl_heading8", h8, 7); chk("rl_dir8", dc8, 9);
    chk("rl_dx8", dx8, -1); chk("rl_dy8", dy8, -1);
    chk("rl_heading16", h16, 15); chk("rl_dx16", dx16, -1); chk("rl_dy16", dy16, -2);
    chk("rl_dir16", dc16, 1);
    rl = 1'b0;

    // Move and rotate on the same tick: move uses the old heading.
    do_reset();
    rr = 1'b1; tick_n(3); chk("pre_move_heading", h8, 2);
    rr = 1'b0; tick_n(1);
    rr = 1'b1; fwd = 1'b1; tick_n(1);
    chk("move_pulse", cap_mv[0], 1); chk("move_dx", cap_dx[0], 1); chk("move_dy", cap_dy[0], 0);
    chk("move_then_heading", h8, 3);
    rr = 1'b0; fwd = 1'b0;

    // Fire cooldown spacing.
    do_reset();
    press_shoot();
    tick_n(1); chk("fire1", cap_fr[0], 1);
    f1 = last_fire_tick[0];
    press_shoot();
    tick_n(4);
    chk("fire_spacing", last_fire_tick[0] - f1, 3);
    chk("two_shots8", sa8, 2);
    chk("one_shot16", sa16, 1);

    // Shot limit, shot_done release, and shot_done coinciding with a fire.
    do_reset();
    press_shoot();
    tick_n(1); chk("lim_fire16", cap_fr[1], 1);
    press_shoot();
    tick_n(2);
    to_tick();
    done = 1'b1; cycle(); done = 1'b0;
    chk("coinc_fire8", cap_fr[0], 1); chk("coinc_shots8", sa8, 1);
    chk("lim_blocked16", cap_fr[1], 0); chk("lim_done16", sa16, 0);
    tick_n(1);
    chk("lim_refire16", cap_fr[1], 1); chk("lim_shots16", sa16, 1);

    // Freeze with keys held, then reset mid-count.
    enable = 1'b0; rr = 1'b1; fwd = 1'b1; shoot = 1'b1;
    hb8 = h8; pb = pulses_obs;
    repeat (20) cycle();
    chk("frozen_pulses", pulses_obs - pb, 0);
    chk("frozen_heading8", h8, hb8);
    enable = 1'b1; rr = 1'b0; fwd = 1'b0; shoot = 1'b0;
    repeat (2) cycle();
    do_reset();
    chk("midrst_heading8", h8, 0); chk("midrst_dir8", dc8, 1);
    chk("midrst_dy8", dy8, -1); chk("midrst_shots8", sa8, 0);
    chk("midrst_move8", mv8, 0); chk("midrst_fire8", fr8, 0);

    // Random play against the model.
    for (int i = 0; i < 800; i++) begin
      reset  = ($urandom_range(0, 149) == 0);
      enable = ($urandom_range(0, 9) != 0);
      rl     = ($urandom_range(0, 2) == 0);
      rr     = ($urandom_range(0, 2) == 0);
      fwd    = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 5) == 0) shoot = ~shoot;
      done   = ($urandom_range(0, 11) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ship_steer_ctrl.md
Name: ship_steer_ctrl

Overview:
Parametrised ship steering and fire controller. Turns held keyboard levels (rotate_left, rotate_right, forward, shoot) into a heading index, a per-heading step vector, a move pulse and rate-limited fire pulses. It sits between the keyboard decoder and the spaceship datapath/renderer. Generalises the fixed 8-way controller to 8 or 16 headings, adds a programmable tick rate, fire cooldown and a live-shot limit.

Parameters:
N_DIR, 8, number of headings; legal values are 8 and 16; heading 0 = north, indices increase clockwise
TICK_DIV, 24'd833333, clk cycles per game tick; minimum 2
ROT_TICKS, 2, ticks between successive rotation steps while a rotate key is held; minimum 1
FIRE_COOLDOWN, 8, ticks after a fire before the next fire is allowed
MAX_SHOTS, 4, maximum shots in flight; range 1..15

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  game running; 0 freezes all state except reset
rotate_left  in  1  level, key held
rotate_right  in  1  level, key held
forward  in  1  level, thrust held
shoot  in  1  level, fire key held
shot_done  in  1  1-cycle pulse; one shot expired or collided
heading  out  $clog2(N_DIR)  current heading index
dir_code  out  4  compass code {W,E,S,N}: 0001 N, 0101 NE, 0100 E, 0110 SE, 0010 S, 1010 SW, 1000 W, 1001 NW
step_dx  out  3  signed x step for the current heading
step_dy  out  3  signed y step for the current heading (negative = up)
move_pulse  out  1  1-cycle pulse; ship advances by step_dx/step_dy
fire_pulse  out  1  1-cycle pulse; spawn a shot at the current heading
shots_active  out  4  shots currently in flight

Behaviour:
- Reset values: heading=0, dir_code=0001, step_dx=0, step_dy=-1 (N_DIR=8) or -2 (N_DIR=16), move_pulse=0, fire_pulse=0, shots_active=0, cooldown=0, fire request clear, tick counter=TICK_DIV-1, rotation counter=0. A reset while enable=1 or mid-tick overrides everything.
- Tick: the down-counter decrements while enable=1. At 0 it asserts an internal tick for one cycle and reloads to TICK_DIV-1. While enable=0 the counter holds and no tick is generated.
- Rotation, evaluated on tick:
  - Exactly one rotate key held: when the rotation counter is 0, heading steps +1 (right) or -1 (left) modulo N_DIR and the counter loads ROT_TICKS-1. Otherwise the counter decrements.
  - Neither key held, or both held: heading holds and the rotation counter clears to 0. The first tick after a press therefore always rotates.
  - Heading wraps N_DIR-1 -> 0 and 0 -> N_DIR-1.
- heading, dir_code, step_dx and step_dy are registered. They update in the same cycle as the heading change, with 0-cycle skew between them.
- Move: on tick with forward=1, move_pulse=1 for that cycle. The step outputs already show the heading in effect before this tick's rotation. Rotation and move on the same tick use the old heading for the move.
- Fire:
  - A rising edge of shoot, sampled every clk, sets the request flag. Edges while the request is set are ignored.
  - On tick, if request=1, cooldown=0 and shots_active<MAX_SHOTS: fire_pulse=1, request clears, cooldown loads FIRE_COOLDOWN.
  - Otherwise the request stays pending and cooldown decrements if it is nonzero.
- shots_active: +1 on fire_pulse, -1 on shot_done (saturates at 0). When both occur in the same cycle, the count is unchanged.
- Step tables, listed clockwise from N as (dx,dy):
  - N_DIR=8: (0,-1)(1,-1)(1,0)(1,1)(0,1)(-1,1)(-1,0)(-1,-1).
  - N_DIR=16: (0,-2)(1,-2)(2,-2)(2,-1)(2,0)(2,1)(2,2)(1,2)(0,2)(-1,2)(-2,2)(-2,1)(-2,0)(-2,-1)(-2,-2)(-1,-2).
- dir_code for 16 headings: odd headings take the code of the octant clockwise of them (heading>>1 rounded up, modulo 8).

Optional Feature:
SHIP_FIRE_AUTOREPEAT_EN
- Defined: while shoot stays held, the request flag re-arms itself every tick. Fire repeats each time cooldown reaches 0 and shots_active<MAX_SHOTS.
- Undefined: edge-triggered only; one press gives at most one fire_pulse.

Decomposition:
- Shared package: heading-table constants (8- and 16-entry dx/dy ROMs), dir_code localparams DIR_N..DIR_NW, and the default TICK_DIV.
- One sub-module, ship_heading_lut: combinational heading -> {dir_code, step_dx, step_dy}, parametrised by N_DIR. The top module registers its outputs.

Test Plan:
- Reset, then N_DIR=8, TICK_DIV=4, ROT_TICKS=2, rotate_right held for 5 ticks -> heading 0->1 (tick1), 2 (tick3), 3 (tick5); dir_code 0101, 0100, 0110; step (1,1) after tick5.
- rotate_left held 1 tick from heading 0 -> heading=7, dir_code=1001, step (-1,-1). Repeat with N_DIR=16 -> heading=15, step (-1,-2).
- forward held plus rotate_right on the same tick at heading 2 -> move_pulse with step (1,0), then heading=3.
- shoot edge with FIRE_COOLDOWN=3 and a second edge 1 tick later -> first fire_pulse on the next tick; second fire_pulse exactly 3 ticks after the first; shots_active=2.
- MAX_SHOTS=1: fire, then press again -> no fire_pulse. Pulse shot_done -> fire_pulse on the next tick. Case where shot_done coincides with fire_pulse -> shots_active stays at 1.
- enable=0 for 20 cycles with keys held -> no pulses and heading frozen. Reset asserted mid-count -> all outputs at reset values in the next cycle.
